// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the 16x8 register-memory controller.
package mem_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    // Request command encodings as presented on ReqCmd.
    typedef enum logic [1:0] {
        CMD_READ  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/mem_addr_dec.sv
// 4-to-16 one-hot row select: address 0 drives the MSB, address 15 the LSB.
module mem_addr_dec
    import mem_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  sel
);

    localparam logic [DEPTH-1:0] TOP_BIT = {1'b1, {(DEPTH-1){1'b0}}};

    // Shift a single set bit down from the top by the address.
    assign sel = TOP_BIT >> addr;

endmodule

// File: rtl/mem_ctrl.sv
// Request/response front end that sequences reads, writes and a full clear
// onto a 16x8 register memory through a one-hot select and write strobe.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [7:0] CLR_VAL = 8'h00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  ReqCmd,
    input  logic [3:0]  ReqAddr,
    input  logic [7:0]  ReqData,
    output logic        RspValid,
    output logic [7:0]  RspData,
    output logic        RspErr,
    output logic [15:0] RegSel,
    output logic        WE,
    output logic [7:0]  DataToWrite,
    input  logic [7:0]  ReadData
);

    state_e            state;
    cmd_e              cmd_q;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] dec_addr;
    logic [DEPTH-1:0]  dec_sel;
    cmd_e              req_cmd;

    assign req_cmd  = cmd_e'(ReqCmd);
    assign ReqReady = (state == IDLE);

    // Pick the address whose select is loaded next: the next clear slot
    // when leaving HOLD, otherwise the incoming request (clear starts at 0).
    always_comb begin
        // NOTE: default assignment first so no path leaves dec_addr unassigned (no latch).
        dec_addr = ReqAddr;
        if (state == HOLD) begin
            dec_addr = cnt + 4'd1;
        end else if (req_cmd == CMD_CLEAR) begin
            dec_addr = '0;
        end
    end

    mem_addr_dec u_dec (
        .addr (dec_addr),
        .sel  (dec_sel)
    );

    // Sequencer with registered memory-side and response outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cmd_q       <= CMD_READ;
            cnt         <= '0;
            RegSel      <= '0;
            WE          <= 1'b0;
            DataToWrite <= '0;
            RspValid    <= 1'b0;
            RspErr      <= 1'b0;
            RspData     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state)
                IDLE: begin
                    if (ReqValid) begin
                        cmd_q <= req_cmd;
                        cnt   <= '0;
                        if (req_cmd == CMD_RSVD) begin
                            state    <= DONE;
                            RspValid <= 1'b1;
                            RspErr   <= 1'b1;
                        end else begin
                            state  <= SETUP;
                            RegSel <= dec_sel;
                            unique case (req_cmd)
                                CMD_WRITE: DataToWrite <= ReqData;
                                CMD_CLEAR: DataToWrite <= CLR_VAL;
                                default:   DataToWrite <= 8'h00;
                            endcase
                        end
                    end
                end
                SETUP: begin
                    if (cmd_q == CMD_READ) begin
                        state    <= DONE;
                        RegSel   <= '0;
                        RspData  <= ReadData;
                        RspValid <= 1'b1;
                    end else begin
                        state <= STROBE;
                        WE    <= 1'b1;
                    end
                end
                STROBE: begin
                    state <= HOLD;
                    WE    <= 1'b0;
                end
                HOLD: begin
                    if (cmd_q == CMD_CLEAR && cnt != 4'hF) begin
                        state  <= SETUP;
                        cnt    <= cnt + 4'd1;
                        RegSel <= dec_sel;
                    end else begin
                        state       <= DONE;
                        RegSel      <= '0;
                        DataToWrite <= 8'h00;
                        RspValid    <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    RspValid <= 1'b0;
                    RspErr   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a behavioural 16x8 register memory
// and a response scoreboard fed by a reference model of the memory contents.
module tb_mem_ctrl;

    localparam logic [7:0] CLR_VAL = 8'h00;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [1:0]  ReqCmd;
    logic [3:0]  ReqAddr;
    logic [7:0]  ReqData;
    logic        RspValid;
    logic [7:0]  RspData;
    logic        RspErr;
    logic [15:0] RegSel;
    logic        WE;
    logic [7:0]  DataToWrite;
    logic [7:0]  ReadData;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         lat;
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        int          lat;
        logic [7:0]  data;
        logic        err;
        int          we_cnt;
        int          we_cyc;
        int          sel_cyc;
        logic [15:0] sel_or;
        logic [7:0]  dtw;
        logic        bad;
        logic        pulse2;
    } obs_t;

    exp_t       sb[$];
    logic [7:0] exp_mem[16];
    logic [7:0] last_rd;
    logic [7:0] mem[16];

    always #5 Clk = ~Clk;

    mem_ctrl #(.CLR_VAL(CLR_VAL)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqCmd      (ReqCmd),
        .ReqAddr     (ReqAddr),
        .ReqData     (ReqData),
        .RspValid    (RspValid),
        .RspData     (RspData),
        .RspErr      (RspErr),
        .RegSel      (RegSel),
        .WE          (WE),
        .DataToWrite (DataToWrite),
        .ReadData    (ReadData)
    );

    // Register memory: one-hot select, write on strobe, asynchronous read.
    always @(posedge Clk) begin
        if (WE) begin
            for (int i = 0; i < 16; i++) begin
                if (RegSel[15-i]) mem[i] <= DataToWrite;
            end
        end
    end

    always_comb begin
        ReadData = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (RegSel[15-i]) ReadData = mem[i];
        end
    end

    // Reference model update and expectation push for one request.
    task automatic model_push(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        e.err  = (cmd == 2'b11);
        e.data = last_rd;
        case (cmd)
            2'b00: begin e.lat = 2; e.data = exp_mem[addr]; last_rd = exp_mem[addr]; end
            2'b01: begin e.lat = 4; exp_mem[addr] = data; end
            2'b10: begin e.lat = 49; for (int i = 0; i < 16; i++) exp_mem[i] = CLR_VAL; end
            default: e.lat = 1;
        endcase
        sb.push_back(e);
    endtask

    // Issue one request and record what the memory side and response did.
    task automatic do_req(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] data, output obs_t o);
        int   w;
        logic seen;
        o = '{default: 0};
        seen = 1'b0;
        @(negedge Clk);
        w = 0;
        while (!ReqReady && w < 10) begin
            @(negedge Clk);
            w++;
        end
        ReqValid = 1'b1;
        ReqCmd   = cmd;
        ReqAddr  = addr;
        ReqData  = data;
        model_push(cmd, addr, data);
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Clk);
            if (WE) begin
                o.we_cnt++;
                o.we_cyc = c;
                if (RegSel == 16'h0) o.bad = 1'b1;
            end
            if (RegSel != 16'h0) begin
                o.sel_cyc++;
                o.sel_or |= RegSel;
                if (!seen) begin
                    o.dtw = DataToWrite;
                    seen  = 1'b1;
                end else if (DataToWrite !== o.dtw) begin
                    o.bad = 1'b1;
                end
            end else if (DataToWrite !== 8'h00) begin
                o.bad = 1'b1;
            end
            if (RspValid) begin
                o.lat  = c;
                o.data = RspData;
                o.err  = RspErr;
                break;
            end
        end
        @(negedge Clk);
        o.pulse2 = RspValid;
    endtask

    // Pop the expectation for the request just observed and compare the response.
    task automatic check_rsp(input string name, input obs_t o);
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL %s scoreboard_empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (o.lat !== e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, o.lat, e.lat); end
        checks++;
        if (o.data !== e.data) begin failures++; $display("FAIL %s rsp_data got=%h exp=%h", name, o.data, e.data); end
        checks++;
        if (o.err !== e.err) begin failures++; $display("FAIL %s rsp_err got=%b exp=%b", name, o.err, e.err); end
        checks++;
        if (o.pulse2 !== 1'b0 || o.bad !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse_or_activity second_pulse=%b bad=%b exp=0/0", name, o.pulse2, o.bad);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({RegSel, WE, DataToWrite, RspValid, RspErr, RspData} !== 35'h0) begin
            failures++;
            $display("FAIL reset_outputs got sel=%h we=%b dtw=%h v=%b e=%b d=%h exp=all zero",
                     RegSel, WE, DataToWrite, RspValid, RspErr, RspData);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (ReqReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ReqReady); end
    endtask

    task automatic test_write_read();
        obs_t o;
        do_req(2'b01, 4'd3, 8'hA5, o);
        check_rsp("wr3", o);
        checks++;
        if (o.sel_or !== 16'h1000 || o.sel_cyc !== 3) begin
            failures++;
            $display("FAIL wr3_regsel got=%h/%0d exp=1000/3", o.sel_or, o.sel_cyc);
        end
        checks++;
        if (o.we_cnt !== 1 || o.we_cyc !== 2) begin
            failures++;
            $display("FAIL wr3_we got=%0d@%0d exp=1@2", o.we_cnt, o.we_cyc);
        end
        checks++;
        if (o.dtw !== 8'hA5) begin failures++; $display("FAIL wr3_dtw got=%h exp=a5", o.dtw); end
        do_req(2'b00, 4'd3, 8'h00, o);
        check_rsp("rd3", o);
        checks++;
        if (o.we_cnt !== 0 || o.sel_or !== 16'h1000 || o.dtw !== 8'h00) begin
            failures++;
            $display("FAIL rd3_memside got we=%0d sel=%h dtw=%h exp=0/1000/00", o.we_cnt, o.sel_or, o.dtw);
        end
    endtask

    task automatic test_boundaries();
        obs_t o;
        do_req(2'b01, 4'd0, 8'h5A, o);
        check_rsp("wr0", o);
        checks++;
        if (o.sel_or !== 16'h8000) begin failures++; $display("FAIL wr0_regsel got=%h exp=8000", o.sel_or); end
        do_req(2'b01, 4'd15, 8'hC3, o);
        check_rsp("wr15", o);
        checks++;
        if (o.sel_or !== 16'h0001) begin failures++; $display("FAIL wr15_regsel got=%h exp=0001", o.sel_or); end
        do_req(2'b00, 4'd0, 8'h00, o);
        check_rsp("rd0", o);
        do_req(2'b00, 4'd15, 8'h00, o);
        check_rsp("rd15", o);
    endtask

    task automatic test_reserved();
        obs_t o;
        do_req(2'b11, 4'd7, 8'h99, o);
        check_rsp("rsvd", o);
        checks++;
        if (o.sel_cyc !== 0 || o.we_cnt !== 0) begin
            failures++;
            $display("FAIL rsvd_activity got sel_cycles=%0d we=%0d exp=0/0", o.sel_cyc, o.we_cnt);
        end
    endtask

    task automatic test_clear();
        obs_t o;
        for (int a = 0; a < 16; a++) begin
            do_req(2'b01, 4'(a), 8'hFF, o);
            check_rsp("fill", o);
        end
        do_req(2'b10, 4'd9, 8'h12, o);
        check_rsp("clear", o);
        checks++;
        if (o.we_cnt !== 16 || o.sel_cyc !== 48 || o.sel_or !== 16'hFFFF) begin
            failures++;
            $display("FAIL clear_sweep got we=%0d sel_cycles=%0d sel=%h exp=16/48/ffff", o.we_cnt, o.sel_cyc, o.sel_or);
        end
        for (int a = 0; a < 16; a++) begin
            do_req(2'b00, 4'(a), 8'h00, o);
            check_rsp("clear_rd", o);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   pulses;
        int   cyc[3];
        exp_t e;
        do_req(2'b01, 4'd9, 8'h3C, o);
        check_rsp("b2b_wr", o);
        @(negedge Clk);
        for (int k = 0; k < 3; k++) model_push(2'b00, 4'd9, 8'h00);
        ReqValid = 1'b1;
        ReqCmd   = 2'b00;
        ReqAddr  = 4'd9;
        pulses   = 0;
        for (int c = 1; c <= 20 && pulses < 3; c++) begin
            @(negedge Clk);
            if (RspValid) begin
                cyc[pulses] = c;
                pulses++;
                e = sb.pop_front();
                checks++;
                if (RspData !== e.data || ReqReady !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_rsp got data=%h ready=%b exp=%h/0", RspData, ReqReady, e.data);
                end
                if (pulses == 3) ReqValid = 1'b0;
            end
        end
        ReqValid = 1'b0;
        checks++;
        if (pulses !== 3 || cyc[0] !== 2 || cyc[1] !== 5 || cyc[2] !== 8) begin
            failures++;
            $display("FAIL b2b_timing got pulses=%0d at %0d,%0d,%0d exp=3 at 2,5,8", pulses, cyc[0], cyc[1], cyc[2]);
            sb.delete();
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset_mid_clear();
        obs_t o;
        int   early;
        do_req(2'b01, 4'd0, 8'h11, o);
        check_rsp("mid_wr0", o);
        do_req(2'b01, 4'd7, 8'h22, o);
        check_rsp("mid_wr7", o);
        do_req(2'b01, 4'd15, 8'h77, o);
        check_rsp("mid_wr15", o);
        @(negedge Clk);
        ReqValid = 1'b1;
        ReqCmd   = 2'b10;
        ReqAddr  = 4'd0;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        early = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if (RspValid) early++;
        end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({RegSel, WE, DataToWrite, RspValid, RspErr, RspData} !== 35'h0 || early !== 0) begin
            failures++;
            $display("FAIL midreset_outputs got sel=%h we=%b dtw=%h v=%b e=%b d=%h early=%0d exp=all zero",
                     RegSel, WE, DataToWrite, RspValid, RspErr, RspData, early);
        end
        Reset = 1'b0;
        // Slots 0..6 had their strobe before reset took effect.
        for (int i = 0; i <= 6; i++) exp_mem[i] = CLR_VAL;
        last_rd = 8'h00;
        early = 0;
        repeat (4) begin
            @(negedge Clk);
            if (RspValid) early++;
        end
        checks++;
        if (early !== 0) begin failures++; $display("FAIL midreset_no_rsp got=%0d exp=0", early); end
        do_req(2'b00, 4'd0, 8'h00, o);
        check_rsp("mid_rd0", o);
        do_req(2'b00, 4'd7, 8'h00, o);
        check_rsp("mid_rd7", o);
        do_req(2'b00, 4'd15, 8'h00, o);
        check_rsp("mid_rd15", o);
    endtask

    initial begin
        Reset    = 1'b1;
        ReqValid = 1'b0;
        ReqCmd   = 2'b00;
        ReqAddr  = 4'd0;
        ReqData  = 8'h00;
        last_rd  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 8'h00;
            mem[i]     = 8'h00;
        end
        test_reset();
        test_write_read();
        test_boundaries();
        test_reserved();
        test_clear();
        test_back_to_back();
        test_reset_mid_clear();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
